l2_miss_scheduler: RTL and testbench

Sits between the L1 instruction cache, the L1 data cache and the shared L2 cache port, and schedules their line-sized misses onto the single L2 request channel. Reads from the two L1s are arbitrated round-robin. D-cache writebacks are absorbed into a one-line write buffer and acknowledged without waiting for L2. Reads that hit the buffered line are forwarded from it. The buffer drains to L2 when the port is idle, or when it has aged out.

---
 rtl/l2_sched_pkg.sv | 21 ++
 rtl/wb_line_buffer.sv | 59 +++++
 rtl/l2_miss_scheduler.sv | 149 ++++++++++++++
 tb/tb_l2_miss_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_sched_pkg.sv
// Shared types and default geometry for the L2 miss scheduler slice.
package l2_sched_pkg;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_LINE_W     = 256;
    localparam int unsigned DEF_OFFSET_W   = 5;
    localparam int unsigned DEF_WB_MAX_AGE = 16;
    localparam int unsigned TAG_W          = DEF_ADDR_W - DEF_OFFSET_W;

    typedef logic [DEF_LINE_W-1:0] line_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT_I = 3'd1,
        GRANT_D = 3'd2,
        DRAIN   = 3'd3,
        RESP_I  = 3'd4,
        RESP_D  = 3'd5
    } sched_state_t;

endpackage

// File: rtl/wb_line_buffer.sv
// One-line D-cache writeback buffer with a saturating age counter and
// line-address match outputs for both read ports.
module wb_line_buffer
    import l2_sched_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned LINE_W     = DEF_LINE_W,
    parameter int unsigned OFFSET_W   = DEF_OFFSET_W,
    parameter int unsigned WB_MAX_AGE = DEF_WB_MAX_AGE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [LINE_W-1:0] fill_data,
    input  logic              clear,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [LINE_W-1:0] wb_data,
    output logic              aged,
    output logic              i_hit,
    output logic              d_hit
);

    localparam int unsigned AGE_W = $clog2(WB_MAX_AGE + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WB_MAX_AGE);

    logic [AGE_W-1:0] wb_age;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            wb_age   <= '0;
        end else begin
            if (clear) begin
                wb_valid <= 1'b0;
            end else if (fill) begin
                wb_valid <= 1'b1;
                wb_addr  <= fill_addr;
                wb_data  <= fill_data;
            end
            // Age counts only cycles the line is actually held.
            if (clear || !wb_valid) begin
                wb_age <= '0;
            end else if (wb_age != AGE_MAX) begin
                wb_age <= wb_age + 1'b1;
            end
        end
    end

    assign aged  = wb_valid && (wb_age == AGE_MAX);
    assign i_hit = wb_valid && (i_addr[ADDR_W-1:OFFSET_W] == wb_addr[ADDR_W-1:OFFSET_W]);
    assign d_hit = wb_valid && (d_addr[ADDR_W-1:OFFSET_W] == wb_addr[ADDR_W-1:OFFSET_W]);

endmodule

// File: rtl/l2_miss_scheduler.sv
// Schedules I-cache and D-cache line misses onto a single L2 port, with
// round-robin read arbitration and a one-line writeback buffer.
module l2_miss_scheduler
    import l2_sched_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned LINE_W     = DEF_LINE_W,
    parameter int unsigned OFFSET_W   = DEF_OFFSET_W,
    parameter int unsigned WB_MAX_AGE = DEF_WB_MAX_AGE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp
);

    sched_state_t      state;
    logic              rr;
    logic [LINE_W-1:0] rdata_q;

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [LINE_W-1:0] wb_data;
    logic              aged;
    logic              i_hit;
    logic              d_hit;
    logic              fill;
    logic              clear;
    logic              both_rd;
    logic              pick_i;
    logic              pick_d;

    assign fill    = (state == IDLE) && !aged && d_write && !wb_valid;
    assign clear   = (state == DRAIN) && l2_resp;
    assign both_rd = i_read && d_read;
    assign pick_i  = both_rd ? !rr : i_read;
    assign pick_d  = both_rd ? rr : (d_read && !i_read);

    wb_line_buffer #(
        .ADDR_W     (ADDR_W),
        .LINE_W     (LINE_W),
        .OFFSET_W   (OFFSET_W),
        .WB_MAX_AGE (WB_MAX_AGE)
    ) u_wb (
        .clk       (clk),
        .rst_n     (rst_n),
        .fill      (fill),
        .fill_addr (d_addr),
        .fill_data (d_wdata),
        .clear     (clear),
        .i_addr    (i_addr),
        .d_addr    (d_addr),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .aged      (aged),
        .i_hit     (i_hit),
        .d_hit     (d_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr      <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (aged) begin
                        state <= DRAIN;
                    end else if (fill) begin
                        state <= RESP_D;
                    end else if (i_read || d_read) begin
                        // On contention the loser gets priority next time.
                        if (both_rd) rr <= ~rr;
                        if (pick_i) begin
                            if (i_hit) begin
                                rdata_q <= wb_data;
                                state   <= RESP_I;
                            end else begin
                                state   <= GRANT_I;
                            end
                        end else if (pick_d) begin
                            if (d_hit) begin
                                rdata_q <= wb_data;
                                state   <= RESP_D;
                            end else begin
                                state   <= GRANT_D;
                            end
                        end
                    end else if (wb_valid) begin
                        state <= DRAIN;
                    end
                end
                GRANT_I: begin
                    if (l2_resp) begin
                        rdata_q <= l2_rdata;
                        state   <= RESP_I;
                    end
                end
                GRANT_D: begin
                    if (l2_resp) begin
                        rdata_q <= l2_rdata;
                        state   <= RESP_D;
                    end
                end
                DRAIN: begin
                    if (l2_resp) state <= IDLE;
                end
                RESP_I:  state <= IDLE;
                RESP_D:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign l2_read  = (state == GRANT_I) || (state == GRANT_D);
    assign l2_write = (state == DRAIN);
    assign l2_wdata = (state == DRAIN) ? wb_data : '0;
    assign i_resp   = (state == RESP_I);
    assign d_resp   = (state == RESP_D);
    assign i_rdata  = rdata_q;
    assign d_rdata  = rdata_q;

    always_comb begin
        l2_address = '0;
        case (state)
            GRANT_I: l2_address = i_addr;
            GRANT_D: l2_address = d_addr;
            DRAIN:   l2_address = wb_addr;
            default: l2_address = '0;
        endcase
    end

endmodule

// File: tb/tb_l2_miss_scheduler.sv
// Directed bench for l2_miss_scheduler with a simple fixed-latency L2 model.
module tb_l2_miss_scheduler;
    import l2_sched_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;

    int    checks    = 0;
    int    failures  = 0;
    int    l2_lat    = 3;
    bit    use_fixed = 1'b0;
    line_t fixed_line;
    int    cnt       = 0;
    int    l2_rd_cnt = 0;
    int    l2_wr_cnt = 0;

    always #5 clk = ~clk;

    l2_miss_scheduler #(
        .ADDR_W     (32),
        .LINE_W     (256),
        .OFFSET_W   (5),
        .WB_MAX_AGE (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_read     (i_read),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .l2_read    (l2_read),
        .l2_write   (l2_write),
        .l2_address (l2_address),
        .l2_wdata   (l2_wdata),
        .l2_rdata   (l2_rdata),
        .l2_resp    (l2_resp)
    );

    // L2 model: responds l2_lat cycles after the request first appears.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l2_resp  <= 1'b0;
            l2_rdata <= '0;
            cnt      <= 0;
        end else if (l2_resp) begin
            l2_resp <= 1'b0;
            cnt     <= 0;
        end else if (l2_read || l2_write) begin
            if (cnt >= l2_lat - 1) begin
                l2_resp  <= 1'b1;
                l2_rdata <= use_fixed ? fixed_line : {8{l2_address}};
                if (l2_write) l2_wr_cnt <= l2_wr_cnt + 1;
                else          l2_rd_cnt <= l2_rd_cnt + 1;
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int   order [4];
        int   got;
        int   nresp;
        int   t;
        int   wr0;
        int   rd0;
        logic prev_i;
        logic prev_d;

        rst_n      = 1'b0;
        i_read     = 1'b0;
        i_addr     = '0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        fixed_line = {32{8'hAA}};
        tick();
        tick();
        chk("rst_l2_read", l2_read, 0);
        chk("rst_l2_write", l2_write, 0);
        chk("rst_i_resp", i_resp, 0);
        chk("rst_d_resp", d_resp, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_l2_address", l2_address, 0);
        rst_n = 1'b1;
        tick();

        // Single I miss, L2 latency 3.
        use_fixed = 1'b1;
        l2_lat    = 3;
        i_read    = 1'b1;
        i_addr    = 32'h0000_0040;
        tick();
        chk("imiss_l2_read", l2_read, 1);
        chk("imiss_l2_addr", l2_address, 32'h40);
        tick();
        tick();
        chk("imiss_early_resp", i_resp, 0);
        tick();
        chk("imiss_resp_at_l2resp", i_resp, 0);
        tick();
        chk("imiss_i_resp", i_resp, 1);
        chk("imiss_i_rdata", i_rdata, {32{8'hAA}});
        chk("imiss_no_d_resp", d_resp, 0);
        chk("imiss_l2_read_drop", l2_read, 0);
        i_read = 1'b0;
        tick();
        chk("imiss_pulse_width", i_resp, 0);

        // Simultaneous reads, round robin.
        use_fixed = 1'b0;
        l2_lat    = 2;
        i_addr    = 32'h200;
        d_addr    = 32'h300;
        i_read    = 1'b1;
        d_read    = 1'b1;
        prev_i    = 1'b0;
        prev_d    = 1'b0;
        got       = 0;
        for (int c = 0; c < 80 && got < 4; c++) begin
            tick();
            if (i_resp && d_resp) chk("rr_dual_resp", 1, 0);
            if (i_resp && got < 4) begin
                order[got] = 0;
                got++;
                chk("rr_i_data", i_rdata, {8{32'h200}});
            end else if (d_resp && got < 4) begin
                order[got] = 1;
                got++;
                chk("rr_d_data", d_rdata, {8{32'h300}});
            end
            if (got < 4) begin
                i_read = !prev_i;
                d_read = !prev_d;
            end else begin
                i_read = 1'b0;
                d_read = 1'b0;
            end
            prev_i = i_resp;
            prev_d = d_resp;
        end
        chk("rr_count", got, 4);
        chk("rr_order0", order[0], 0);
        chk("rr_order1", order[1], 1);
        chk("rr_order2", order[2], 0);
        chk("rr_order3", order[3], 1);
        tick();
        tick();
        chk("rr_quiet", l2_read, 0);

        // Writeback absorb and forward.
        wr0     = l2_wr_cnt;
        rd0     = l2_rd_cnt;
        d_write = 1'b1;
        d_addr  = 32'h100;
        d_wdata = {32{8'h55}};
        tick();
        chk("wb_d_resp", d_resp, 1);
        chk("wb_no_l2_write", l2_write, 0);
        d_write = 1'b0;
        i_read  = 1'b1;
        i_addr  = 32'h11C;
        tick();
        chk("fwd_no_early_resp", i_resp, 0);
        chk("fwd_no_l2_read_a", l2_read, 0);
        tick();
        chk("fwd_i_resp", i_resp, 1);
        chk("fwd_i_rdata", i_rdata, {32{8'h55}});
        chk("fwd_d_rdata", d_rdata, {32{8'h55}});
        chk("fwd_no_l2_read_b", l2_read, 0);
        i_read = 1'b0;

        // Idle drain.
        tick();
        tick();
        chk("drain_l2_write", l2_write, 1);
        chk("drain_addr", l2_address, 32'h100);
        chk("drain_wdata", l2_wdata, {32{8'h55}});
        for (int c = 0; c < 20 && l2_write; c++) tick();
        chk("drain_done", l2_write, 0);
        chk("drain_wb_valid", dut.u_wb.wb_valid, 0);
        chk("drain_wr_count", l2_wr_cnt, wr0 + 1);
        chk("fwd_rd_count", l2_rd_cnt, rd0);

        // Aging: held non-matching read, L2 latency 2.
        d_write = 1'b1;
        d_addr  = 32'h400;
        d_wdata = {32{8'h33}};
        tick();
        chk("age_fill_resp", d_resp, 1);
        d_write = 1'b0;
        i_read  = 1'b1;
        i_addr  = 32'h800;
        nresp   = 0;
        t       = 0;
        for (int c = 1; c <= 40 && !l2_write; c++) begin
            tick();
            if (i_resp) nresp++;
            t = c;
        end
        chk("age_drain_seen", l2_write, 1);
        chk("age_drain_cycle", t, 17);
        chk("age_reads_before", nresp, 3);
        chk("age_drain_addr", l2_address, 32'h400);
        chk("age_drain_wdata", l2_wdata, {32{8'h33}});
        chk("age_saturated", dut.u_wb.wb_age, 16);
        for (int c = 0; c < 40 && !i_resp; c++) tick();
        chk("age_read_after", i_resp, 1);
        chk("age_read_data", i_rdata, {8{32'h800}});
        chk("age_wb_cleared", dut.u_wb.wb_valid, 0);
        i_read = 1'b0;
        tick();
        tick();

        // Reset during GRANT_D.
        d_write = 1'b1;
        d_addr  = 32'h500;
        d_wdata = {32{8'h77}};
        tick();
        chk("rstg_fill_resp", d_resp, 1);
        d_write = 1'b0;
        d_read  = 1'b1;
        d_addr  = 32'h900;
        l2_lat  = 1000;
        tick();
        tick();
        chk("rstg_l2_read", l2_read, 1);
        chk("rstg_l2_addr", l2_address, 32'h900);
        tick();
        tick();
        chk("rstg_held", l2_read, 1);
        rst_n  = 1'b0;
        d_read = 1'b0;
        #1;
        chk("rstg_l2_read_clr", l2_read, 0);
        chk("rstg_d_resp_clr", d_resp, 0);
        chk("rstg_wb_valid_clr", dut.u_wb.wb_valid, 0);
        chk("rstg_l2_addr_clr", l2_address, 0);
        tick();
        tick();
        rst_n  = 1'b1;
        l2_lat = 2;
        i_read = 1'b1;
        i_addr = 32'h40;
        tick();
        chk("post_rst_l2_read", l2_read, 1);
        chk("post_rst_l2_addr", l2_address, 32'h40);
        for (int c = 0; c < 20 && !i_resp; c++) tick();
        chk("post_rst_i_resp", i_resp, 1);
        chk("post_rst_i_rdata", i_rdata, {8{32'h40}});
        i_read = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
